// File: rtl/frame_pattern_gen.sv
// Frame pattern generator: emits vsync / active / blanking sequences with a
// selectable test pattern (checkerboard, ramp, LFSR, cross) behind a ready/valid handshake.
module frame_pattern_gen #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int DATA_W  = 1,
    parameter int VS_LEN  = 4,
    parameter int H_BLANK = 8,
    parameter int V_BLANK = 16
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [7:0]        num_frames,
    input  logic [15:0]       seed,
    input  logic              out_rdy,
    output logic              vsync,
    output logic              bin_data_vld,
    output logic [DATA_W-1:0] bin_data,
    output logic              line_end,
    output logic              frame_done,
    output logic              busy
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_VBLANK = 3'd4;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [DATA_W-1:0] pixel(input logic [1:0] m, input logic [XW-1:0] px,
                                                input logic [YW-1:0] py, input logic [15:0] l);
        logic [11:0] sum;
        logic [DATA_W-1:0] v;
        sum = 12'(px) + 12'(py);
        case (m)
            2'd0:    v = {DATA_W{px[0] ^ py[0]}};
            2'd1:    v = DATA_W'(px);
            2'd2:    v = l[DATA_W-1:0];
            default: v = {DATA_W{(12'(px) == 12'(py)) || (sum == 12'(IMG_W - 1))}};
        endcase
        return v;
    endfunction

    logic [2:0]        state, state_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic [XW-1:0]     x, x_nxt, x_inc;
    logic [YW-1:0]     y, y_nxt;
    logic [15:0]       lfsr, lfsr_nxt, lfsr_adv;
    logic [15:0]       seed_r, seed_nxt;
    logic [1:0]        mode_r, mode_nxt;
    logic [7:0]        nf_r, nf_nxt;
    logic [7:0]        frames, frames_nxt, frames_inc;
    logic              stop_lat, stop_lat_nxt;
    logic              vsync_nxt, vld_nxt, le_nxt, fd_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              xfer, last_x, last_y, seq_end;

    // x/y/lfsr always describe the pixel currently (or next) presented on bin_data.
    always_comb begin
        xfer       = bin_data_vld && out_rdy;
        x_inc      = x + XW'(1);
        lfsr_adv   = lfsr_step(lfsr);
        frames_inc = frames + 8'd1;
        last_x     = (x == XW'(IMG_W - 1));
        last_y     = (y == YW'(IMG_H - 1));
        seq_end    = ((nf_r != 8'd0) && (frames_inc == nf_r)) || stop_lat || stop;

        state_nxt    = state;
        cnt_nxt      = cnt;
        x_nxt        = x;
        y_nxt        = y;
        lfsr_nxt     = lfsr;
        seed_nxt     = seed_r;
        mode_nxt     = mode_r;
        nf_nxt       = nf_r;
        frames_nxt   = frames;
        stop_lat_nxt = stop_lat || ((state != S_IDLE) && stop);
        vsync_nxt    = vsync;
        vld_nxt      = bin_data_vld;
        data_nxt     = bin_data;
        le_nxt       = line_end;
        fd_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_VSYNC;
                    cnt_nxt    = 16'(VS_LEN - 1);
                    vsync_nxt  = 1'b1;
                    mode_nxt   = mode;
                    nf_nxt     = num_frames;
                    seed_nxt   = (seed == 16'd0) ? LFSR_DEFAULT : seed;
                    lfsr_nxt   = (seed == 16'd0) ? LFSR_DEFAULT : seed;
                    x_nxt      = '0;
                    y_nxt      = '0;
                    frames_nxt = 8'd0;
                end
            end
            S_VSYNC: begin
                if (cnt == 16'd0) begin
                    state_nxt = S_ACTIVE;
                    vsync_nxt = 1'b0;
                    vld_nxt   = 1'b1;
                    data_nxt  = pixel(mode_r, x, y, lfsr);
                    le_nxt    = last_x;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_ACTIVE: begin
                if (xfer) begin
                    lfsr_nxt = lfsr_adv;
                    if (last_x) begin
                        vld_nxt = 1'b0;
                        le_nxt  = 1'b0;
                        x_nxt   = '0;
                        if (last_y) begin
                            state_nxt = S_VBLANK;
                            cnt_nxt   = 16'(V_BLANK - 1);
                        end else begin
                            state_nxt = S_HBLANK;
                            cnt_nxt   = 16'(H_BLANK - 1);
                            y_nxt     = y + YW'(1);
                        end
                    end else begin
                        x_nxt    = x_inc;
                        data_nxt = pixel(mode_r, x_inc, y, lfsr_adv);
                        le_nxt   = (x_inc == XW'(IMG_W - 1));
                    end
                end
            end
            S_HBLANK: begin
                if (cnt == 16'd0) begin
                    state_nxt = S_ACTIVE;
                    vld_nxt   = 1'b1;
                    data_nxt  = pixel(mode_r, x, y, lfsr);
                    le_nxt    = last_x;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            S_VBLANK: begin
                if (cnt == 16'd0) begin
                    fd_nxt     = 1'b1;
                    frames_nxt = frames_inc;
                    if (seq_end) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_VSYNC;
                        cnt_nxt   = 16'(VS_LEN - 1);
                        vsync_nxt = 1'b1;
                        lfsr_nxt  = seed_r;
                        x_nxt     = '0;
                        y_nxt     = '0;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                vsync_nxt = 1'b0;
                vld_nxt   = 1'b0;
                le_nxt    = 1'b0;
            end
        endcase

        if (state_nxt == S_IDLE) stop_lat_nxt = 1'b0;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            x            <= '0;
            y            <= '0;
            lfsr         <= '0;
            seed_r       <= '0;
            mode_r       <= '0;
            nf_r         <= '0;
            frames       <= '0;
            stop_lat     <= 1'b0;
            vsync        <= 1'b0;
            bin_data_vld <= 1'b0;
            bin_data     <= '0;
            line_end     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            lfsr         <= lfsr_nxt;
            seed_r       <= seed_nxt;
            mode_r       <= mode_nxt;
            nf_r         <= nf_nxt;
            frames       <= frames_nxt;
            stop_lat     <= stop_lat_nxt;
            vsync        <= vsync_nxt;
            bin_data_vld <= vld_nxt;
            bin_data     <= data_nxt;
            line_end     <= le_nxt;
            frame_done   <= fd_nxt;
            busy         <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/frame_pattern_gen.md
FRAME_PATTERN_GEN -- requirements
Module: frame_pattern_gen

Interface
REQ-001 Parameter IMG_W, default 28, active pixels per line (2..1024).
REQ-002 Parameter IMG_H, default 28, active lines per frame (2..1024).
REQ-003 Parameter DATA_W, default 1, pixel width in bits (1..16).
REQ-004 Parameter VS_LEN, default 4, vsync pulse length in cycles (>=1).
REQ-005 Parameter H_BLANK, default 8, idle cycles between lines (>=1).
REQ-006 Parameter V_BLANK, default 16, idle cycles after last line (>=1).
REQ-007 sclk  input  1  system clock; all logic on rising edge.
REQ-008 s_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  single-cycle request to begin a frame sequence.
REQ-010 stop  input  1  single-cycle request to end the sequence after the current frame.
REQ-011 mode  input  2  pattern select, sampled at accepted start.
REQ-012 num_frames  input  8  frames to emit, sampled at start; 0 = continuous.
REQ-013 seed  input  16  LFSR seed, sampled at start.
REQ-014 out_rdy  input  1  downstream ready.
REQ-015 vsync  output  1  frame start pulse.
REQ-016 bin_data_vld  output  1  pixel valid.
REQ-017 bin_data  output  DATA_W  pixel value.
REQ-018 line_end  output  1  high with the last pixel of each line.
REQ-019 frame_done  output  1  one-cycle pulse after each frame's V_BLANK.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 FSM states SHALL be IDLE, VSYNC, ACTIVE, HBLANK, VBLANK.
- IDLE -> VSYNC on start; start ignored when busy.
- VSYNC: vsync=1 for exactly VS_LEN cycles -> ACTIVE.
- ACTIVE -> HBLANK after pixel IMG_W-1 transfers on lines 0..IMG_H-2; -> VBLANK after last pixel of line IMG_H-1.
- HBLANK: H_BLANK cycles -> ACTIVE.
- VBLANK: V_BLANK cycles, then frame_done pulse, then VSYNC if more frames pending and no stop latched, else IDLE.
REQ-023 vsync SHALL rise the cycle after the accepted start (latency 1).
REQ-024 bin_data_vld SHALL be high only in ACTIVE; a transfer occurs on bin_data_vld && out_rdy.
REQ-025 While bin_data_vld=1 and out_rdy=0, bin_data, bin_data_vld and line_end SHALL hold stable.
REQ-026 Pixel counters x (0..IMG_W-1), y (0..IMG_H-1) SHALL advance only on transfer; x wraps to 0 at line end.
REQ-027 Pattern by mode (x,y of the pixel presented):
- 0: checkerboard, all bits = (x^y)[0].
- 1: ramp, bin_data = x mod 2^DATA_W.
- 2: LFSR, 16-bit Fibonacci x^16+x^14+x^13+x^11+1, bin_data = lfsr[DATA_W-1:0], advanced per transfer; seed 0 SHALL be replaced by 16'hACE1; reloaded from seed at every frame start.
- 3: cross, all bits = (x==y) || (x+y==IMG_W-1).
REQ-028 stop SHALL be latched while busy and cleared on entering IDLE; it never truncates a frame in progress.
REQ-029 Frame counter SHALL count frame_done pulses; sequence ends after num_frames frames (num_frames>0).
REQ-030 start and stop in the same IDLE cycle: start accepted, stop ignored.

Reset
REQ-031 On s_rst_n=0, state SHALL go to IDLE and vsync, bin_data_vld, bin_data, line_end, frame_done, busy SHALL be 0 immediately, including mid-frame.
REQ-032 After reset release, no output SHALL change until a start is accepted.

Verification
REQ-033 Defaults, mode=0, num_frames=1, out_rdy=1, start pulse -> vsync high 4 cycles from cycle+1, 784 transfers, first pixel 1'b0, second 1'b1, 28 line_end pulses, one frame_done, busy low after.
REQ-034 DATA_W=8, mode=1, out_rdy toggled 1/0 each cycle -> values 0..27 per line, no duplicates or drops, data stable during stalls.
REQ-035 mode=2, seed=0 -> first pixel bits = 16'hACE1 low bits; second frame repeats identical sequence.
REQ-036 num_frames=0, stop pulsed mid-frame 2 -> frame 2 completes fully, frame_done count 2, then IDLE.
REQ-037 s_rst_n low during line 10 -> all outputs 0 asynchronously; new start yields complete frame from x=0,y=0.
REQ-038 start pulsed while busy -> ignored; frame count and timing unchanged.
